// File: rtl/crc_framer_pkg.sv
// rtl/crc_framer_pkg.sv - shared FSM states, CRC constants and byte-wise CRC helpers
package crc_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_CHKTRL,
        ST_FLUSH
    } state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC16_POLY = 32'h0000_1021;
    localparam logic [31:0] CRC16_INIT = 32'h0000_FFFF;

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Non-reflected Galois update, d[7] shifted in first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d,
                                             input int w, input logic [31:0] poly);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[w-1] ^ d[i];
            c  = (c << 1) & width_mask(w);
            if (fb) c = c ^ (poly & width_mask(w));
        end
        return c;
    endfunction

    // legacy=1: byte k is F[8k+7:8k] bit-reversed; legacy=0: MSB byte first.
    function automatic logic [7:0] trail_byte(input logic [31:0] f, input int k,
                                              input int w, input logic legacy);
        logic [31:0] t;
        logic [7:0]  b;
        if (legacy) begin
            t = f >> (8 * k);
            for (int i = 0; i < 8; i++) b[7-i] = t[i];
        end else begin
            t = f >> (w - 8 - 8 * k);
            b = t[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/crc_framer_crc_byte_engine.sv
// rtl/crc_framer_crc_byte_engine.sv - CRC register with one-byte-per-cycle update
module crc_byte_engine
    import crc_framer_pkg::*;
#(
    parameter int          CRC_W = 32,
    parameter logic [31:0] POLY  = CRC32_POLY,
    parameter logic [31:0] INIT  = CRC32_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             en,
    input  logic [7:0]       d,
    output logic [CRC_W-1:0] q
);
    localparam logic [31:0] INIT_M = INIT & width_mask(CRC_W);

    logic [31:0] r_crc;
    logic [31:0] w_next;

    assign w_next = crc_next(r_crc, d, CRC_W, POLY);
    assign q      = r_crc[CRC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_crc <= INIT_M;
        else if (init) r_crc <= INIT_M;
        else if (en)   r_crc <= w_next;
    end

endmodule

// File: rtl/crc_framer.sv
// rtl/crc_framer.sv - byte-stream framer appending or checking a CRC trailer
module crc_framer
    import crc_framer_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] XOROUT     = 32'h0,
    parameter int          TRAIL_MODE = 1,
    parameter int          LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_check,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             done,
    output logic             crc_ok
);
    localparam int          NB       = CRC_W / 8;
    localparam logic [1:0]  LAST_K   = 2'(NB - 1);
    localparam logic [31:0] XOROUT_M = XOROUT & width_mask(CRC_W);

    state_t           r_state, w_state_nx;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [1:0]       r_k;
    logic             r_check, r_mis, r_done, r_ok;
    logic [7:0]       r_m_data;
    logic             r_m_valid, r_m_last;
    logic [CRC_W-1:0] w_crc;
    logic [31:0]      w_crc32, w_f;
    logic [7:0]       w_exp;
    logic             w_out_free, w_s_ready, w_s_hs, w_m_hs;
    logic             w_crc_en, w_crc_init, w_last_pay;

    crc_byte_engine #(.CRC_W(CRC_W), .POLY(POLY), .INIT(INIT)) u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_crc_init),
        .en    (w_crc_en),
        .d     (s_data),
        .q     (w_crc)
    );

    always_comb begin
        w_crc32            = '0;
        w_crc32[CRC_W-1:0] = w_crc;
    end

    assign w_f        = w_crc32 ^ XOROUT_M;
    assign w_exp      = trail_byte(w_f, int'(r_k), CRC_W, TRAIL_MODE == 1);
    assign w_out_free = !r_m_valid || m_ready;
    assign w_s_hs     = s_valid && w_s_ready;
    assign w_m_hs     = r_m_valid && m_ready;
    assign w_crc_en   = w_s_hs && (r_state == ST_IDLE || r_state == ST_PAYLOAD);
    assign w_crc_init = (r_state == ST_FLUSH) && w_m_hs;
    assign w_last_pay = (r_state == ST_IDLE) ? (cfg_len == LEN_W'(1))
                                             : ((r_cnt + 1'b1) == r_len);

    // An empty frame in IDLE must not swallow the byte that announced it.
    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            ST_IDLE:               w_s_ready = w_out_free && (cfg_len != '0);
            ST_PAYLOAD, ST_CHKTRL: w_s_ready = w_out_free;
            default:               w_s_ready = 1'b0;
        endcase
        if (!rst_n) w_s_ready = 1'b0;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (s_valid && (cfg_len == '0 || w_s_hs)) begin
                    if (cfg_len == '0 || w_last_pay) w_state_nx = cfg_check ? ST_CHKTRL : ST_TRAILER;
                    else                             w_state_nx = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (w_s_hs && w_last_pay) w_state_nx = r_check ? ST_CHKTRL : ST_TRAILER;
            ST_TRAILER: if (w_out_free && r_k == LAST_K) w_state_nx = ST_FLUSH;
            ST_CHKTRL:  if (w_s_hs && r_k == LAST_K) w_state_nx = ST_FLUSH;
            ST_FLUSH:   if (w_m_hs) w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_check <= 1'b0;
            r_mis   <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_crc_init;
            r_ok    <= w_crc_init && r_check && !r_mis;
            case (r_state)
                ST_IDLE: begin
                    r_k   <= '0;
                    r_mis <= 1'b0;
                    if (s_valid) begin
                        r_len   <= cfg_len;
                        r_check <= cfg_check;
                        r_cnt   <= w_s_hs ? LEN_W'(1) : '0;
                    end
                end
                ST_PAYLOAD: if (w_s_hs) r_cnt <= r_cnt + 1'b1;
                ST_TRAILER: if (w_out_free) r_k <= r_k + 1'b1;
                ST_CHKTRL: begin
                    if (w_s_hs) begin
                        r_k   <= r_k + 1'b1;
                        r_mis <= r_mis | (s_data != w_exp);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_out_free) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (w_s_hs) begin
                r_m_data  <= s_data;
                r_m_valid <= 1'b1;
                r_m_last  <= (r_state == ST_CHKTRL) && (r_k == LAST_K);
            end else if (r_state == ST_TRAILER) begin
                r_m_data  <= w_exp;
                r_m_valid <= 1'b1;
                r_m_last  <= (r_k == LAST_K);
            end
        end
    end

    assign s_ready = w_s_ready;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign done    = r_done;
    assign crc_ok  = r_ok;

endmodule

// File: tb/tb_crc_framer.sv
// tb/tb_crc_framer.sv - randomized self-checking bench for crc_framer against a division model
module tb_crc_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] cfg_len   [3];
    logic       cfg_check [3];
    logic [7:0] s_data    [3];
    logic       s_valid   [3];
    logic       m_ready   [3];
    wire        s_ready   [3];
    wire  [7:0] m_data    [3];
    wire        m_valid   [3];
    wire        m_last    [3];
    wire        done      [3];
    wire        crc_ok    [3];

    crc_framer u_dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len[0]), .cfg_check(cfg_check[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_last(m_last[0]), .done(done[0]), .crc_ok(crc_ok[0])
    );

    crc_framer #(.TRAIL_MODE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len[1]), .cfg_check(cfg_check[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_last(m_last[1]), .done(done[1]), .crc_ok(crc_ok[1])
    );

    crc_framer #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .TRAIL_MODE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len[2]), .cfg_check(cfg_check[2]),
        .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .m_data(m_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
        .m_last(m_last[2]), .done(done[2]), .crc_ok(crc_ok[2])
    );

    int          w_of    [3] = '{32, 32, 16};
    logic [31:0] poly_of [3] = '{32'h04C11DB7, 32'h04C11DB7, 32'h1021};
    logic [31:0] init_of [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF};
    int          mode_of [3] = '{1, 0, 0};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of (INIT*x^(8n) + M*x^w) divided by x^w + POLY.
    function automatic logic [31:0] ref_crc(input logic [7:0] m[$], input int w,
                                            input logic [31:0] poly, input logic [31:0] init);
        bit          d[$];
        int          len;
        logic [31:0] r;
        len = 8 * m.size() + w;
        for (int i = 0; i < len; i++) d.push_back(1'b0);
        for (int i = 0; i < w; i++) d[i] = d[i] ^ init[w-1-i];
        foreach (m[b]) for (int j = 0; j < 8; j++) d[8*b+j] = d[8*b+j] ^ m[b][7-j];
        for (int i = 0; i < len - w; i++)
            if (d[i]) begin
                d[i] = 1'b0;
                for (int j = 1; j <= w; j++) d[i+j] = d[i+j] ^ poly[w-j];
            end
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = d[len-w+i];
        return r;
    endfunction

    function automatic void ref_trailer(input logic [31:0] f, input int w, input int mode,
                                        output logic [7:0] t[$]);
        logic [7:0] b;
        t = {};
        for (int k = 0; k < w / 8; k++) begin
            if (mode == 1) begin
                b = 8'(f >> (8 * k));
                b = {<<{b}};
            end else begin
                b = 8'(f >> (w - 8 - 8 * k));
            end
            t.push_back(b);
        end
    endfunction

    int         sel = 0;
    logic       bp_en = 1'b0;
    wire  [7:0] mon_data  = m_data[sel];
    wire        mon_valid = m_valid[sel];
    wire        mon_ready = m_ready[sel];
    wire        mon_last  = m_last[sel];
    wire        mon_done  = done[sel];
    wire        mon_ok    = crc_ok[sel];

    logic [8:0] outq[$];
    int         n_done, n_sacc;
    logic       ok_seen;
    logic       stall_prev = 1'b0;
    logic [8:0] held;

    initial forever begin
        for (int i = 0; i < 3; i++) m_ready[i] = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) check("stall_hold", {mon_valid, mon_last, mon_data}, {1'b1, held});
            if (mon_valid && mon_ready) outq.push_back({mon_last, mon_data});
            stall_prev = mon_valid && !mon_ready;
            held       = {mon_last, mon_data};
            if (s_valid[sel] && s_ready[sel]) n_sacc++;
            if (mon_done) begin
                n_done++;
                ok_seen = mon_ok;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_bytes(input int d, input logic [7:0] tx[$], input string tag);
        int   budget;
        logic acc;
        foreach (tx[i]) begin
            s_data[d]  = tx[i];
            s_valid[d] = 1'b1;
            budget     = 0;
            acc        = 1'b0;
            while (!acc && budget < 200) begin
                @(negedge clk);
                acc = s_ready[d];
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) check({tag, " accept_timeout"}, 32'd0, 32'd1);
        end
        s_valid[d] = 1'b0;
    endtask

    task automatic run_frame(input int d, input logic chk, input logic [7:0] pay[$],
                             input logic [7:0] trl[$], input logic exp_ok, input string tag);
        logic [7:0] tx[$];
        logic [8:0] exp[$];
        int         budget;
        sel = d;
        @(posedge clk);
        #1;
        outq.delete();
        n_done  = 0;
        n_sacc  = 0;
        ok_seen = 1'b0;
        foreach (pay[i]) exp.push_back({1'b0, pay[i]});
        foreach (trl[i]) exp.push_back({i == trl.size() - 1, trl[i]});
        tx = pay;
        if (chk) foreach (trl[i]) tx.push_back(trl[i]);
        cfg_len[d]   = 8'(pay.size());
        cfg_check[d] = chk;
        if (tx.size() == 0) begin
            s_data[d]  = 8'($urandom);
            s_valid[d] = 1'b1;
            @(posedge clk);
            #1;
            s_valid[d] = 1'b0;
        end else begin
            push_bytes(d, tx, tag);
        end
        budget = 0;
        while (n_done == 0 && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        @(negedge clk);
        check({tag, " done"}, n_done, 1);
        check({tag, " crc_ok"}, ok_seen, exp_ok);
        check({tag, " accepted"}, n_sacc, tx.size());
        check({tag, " count"}, outq.size(), exp.size());
        foreach (exp[i])
            check($sformatf("%s byte%0d", tag, i), (i < outq.size()) ? 32'(outq[i]) : 32'hDEAD, exp[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " m_data"},  m_data[0],  0);
        check({tag, " m_valid"}, m_valid[0], 0);
        check({tag, " m_last"},  m_last[0],  0);
        check({tag, " done"},    done[0],    0);
        check({tag, " crc_ok"},  crc_ok[0],  0);
        check({tag, " s_ready"}, s_ready[0], 0);
    endtask

    logic [7:0] pay9[$], part[$], none[$], t_leg[$], t_msb[$], t_16[$], t_bad[$], t_ff[$];
    logic [7:0] rp[$], rt[$];

    initial begin
        pay9  = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        part  = {8'h31, 8'h32, 8'h33, 8'h34};
        t_leg = {8'hE7, 8'h67, 8'h6E, 8'hC0};
        t_bad = {8'hE7, 8'h67, 8'h6E, 8'hC1};
        t_msb = {8'h03, 8'h76, 8'hE6, 8'hE7};
        t_16  = {8'h29, 8'hB1};
        t_ff  = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_len[i]   = 8'd9;
            cfg_check[i] = 1'b0;
            s_data[i]    = 8'h00;
            s_valid[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        for (int i = 0; i < 3; i++) s_valid[i] = 1'b0;
        rst_n = 1'b1;

        run_frame(0, 1'b0, pay9, t_leg, 1'b0, "gen32");
        run_frame(1, 1'b0, pay9, t_msb, 1'b0, "gen32msb");
        run_frame(2, 1'b0, pay9, t_16,  1'b0, "gen16");
        run_frame(0, 1'b1, pay9, t_leg, 1'b1, "chk_good");
        run_frame(0, 1'b1, pay9, t_bad, 1'b0, "chk_bad");
        bp_en = 1'b1;
        run_frame(0, 1'b0, pay9, t_leg, 1'b0, "gen32_bp");
        bp_en = 1'b0;
        run_frame(0, 1'b0, none, t_ff, 1'b0, "len0");

        sel          = 0;
        cfg_len[0]   = 8'd9;
        cfg_check[0] = 1'b0;
        push_bytes(0, part, "rst_pre");
        s_data[0]  = 8'h35;
        s_valid[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        rst_n      = 1'b1;
        run_frame(0, 1'b0, pay9, t_leg, 1'b0, "after_rst");

        for (int r = 0; r < 10; r++) begin
            int   d, len;
            logic chk, ok;
            d   = $urandom_range(0, 2);
            chk = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 14);
            rp  = {};
            for (int i = 0; i < len; i++) rp.push_back(8'($urandom));
            ref_trailer(ref_crc(rp, w_of[d], poly_of[d], init_of[d]), w_of[d], mode_of[d], rt);
            ok = chk;
            if (chk && $urandom_range(0, 1) == 1) begin
                int k;
                k     = $urandom_range(0, rt.size() - 1);
                rt[k] = rt[k] ^ 8'($urandom_range(1, 255));
                ok    = 1'b0;
            end
            bp_en = 1'($urandom_range(0, 1));
            run_frame(d, chk, rp, rt, ok, $sformatf("rnd%0d", r));
            bp_en = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/crc_framer.md
CRC_FRAMER -- requirements
Module: crc_framer

Interface
REQ-001 SHALL have parameter CRC_W, default 32, CRC width; legal values 16 and 32.
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7, generator polynomial; low CRC_W bits used.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF, register preset at frame start.
REQ-004 SHALL have parameter XOROUT, default 32'h0, XORed into the final CRC before trailer emit or compare.
REQ-005 SHALL have parameter TRAIL_MODE, default 1.
  - 1 = legacy order: low byte first, each byte bit-reversed.
  - 0 = MSB byte first, no reversal.
REQ-006 SHALL have parameter LEN_W, default 8, width of cfg_len.
REQ-007 Ports, in order:
  - clk  in  1  sole clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - cfg_len  in  LEN_W  payload byte count; sampled on first accepted byte.
  - cfg_check  in  1  mode, sampled with cfg_len: 0 generate/append, 1 check received trailer.
  - s_data  in  8  input byte.
  - s_valid  in  1  input byte valid.
  - s_ready  out  1  block accepts s_data this cycle.
  - m_data  out  8  output byte (registered).
  - m_valid  out  1  output valid.
  - m_ready  in  1  downstream accepts.
  - m_last  out  1  marks final byte of frame.
  - done  out  1  one-cycle pulse at end of frame.
  - crc_ok  out  1  check result, valid with done; 0 in generate mode.

Function
REQ-008 Transfers SHALL occur on s_valid&&s_ready (input) and m_valid&&m_ready (output); m_data/m_valid/m_last SHALL hold while m_valid&&!m_ready.
REQ-009 s_ready SHALL equal (state in IDLE/PAYLOAD/CHKTRL) && (!m_valid || m_ready).
REQ-010 The CRC update SHALL process 8 bits per byte, MSB-first, s_data[7] first, non-reflected, Galois form with POLY.
REQ-011 FSM states and transitions:
  - IDLE -> PAYLOAD on first accepted byte, with crc = update(INIT, byte).
  - IDLE -> TRAILER when cfg_len==0 in generate mode, or -> CHKTRL in check mode, on the cycle s_valid is seen; no byte is consumed.
REQ-012 PAYLOAD SHALL count accepted bytes.
  - After byte cfg_len: generate mode -> TRAILER, check mode -> CHKTRL.
REQ-013 TRAILER SHALL emit CRC_W/8 bytes of F = crc^XOROUT, one per output transfer, with s_ready=0.
  - TRAIL_MODE=1: byte k has bit (7-i) = F[8k+i].
  - TRAIL_MODE=0: byte k = F[CRC_W-1-8k -: 8].
REQ-014 CHKTRL SHALL accept CRC_W/8 trailer bytes, pass them through unchanged, and compare each against expected byte k per REQ-013.
REQ-015 Payload bytes SHALL be forwarded to m_data with one cycle latency; no bubble between last payload byte and first trailer byte when m_ready=1.
REQ-016 m_last SHALL assert on the final trailer byte.
  - done SHALL pulse the cycle after that byte transfers; crc_ok = all compares matched (check mode).
  - FSM SHALL then return to IDLE with crc reloaded to INIT.
REQ-017 Peak throughput SHALL be one byte/cycle; frame cost = cfg_len + CRC_W/8 cycles with no stalls.
REQ-018 cfg_len/cfg_check changes mid-frame SHALL be ignored until IDLE.

Reset
REQ-019 rst_n low SHALL asynchronously force:
  - state IDLE, crc INIT, counters 0;
  - m_data 8'h00, m_valid 0, m_last 0, done 0, crc_ok 0, s_ready 0.
REQ-020 Reset deassertion mid-frame SHALL discard the partial frame; the next accepted byte starts a new frame.

Structure
REQ-021 A shared package SHALL hold:
  - the FSM state enum;
  - the byte-wise CRC next-state function (parametrised by CRC_W and POLY);
  - the trailer byte-select function;
  - the CRC32/CRC16 default constants.
REQ-022 The CRC register and update function SHALL be one sub-module, crc_byte_engine, with ports clk, rst_n, init, en, d, q.

Verification
REQ-023 Generate, defaults, cfg_len=9, payload "123456789", m_ready=1 -> 9 bytes echoed, then trailer E7 67 6E C0, m_last on C0, done pulses.
REQ-024 Same payload, TRAIL_MODE=0 -> trailer 03 76 E6 E7; with CRC_W=16, POLY=1021, INIT=FFFF -> trailer 29 B1.
REQ-025 Check mode, legacy defaults, "123456789"+E7 67 6E C0 -> crc_ok=1; same frame with last byte C1 -> crc_ok=0; 13 bytes forwarded in both cases.
REQ-026 Random m_ready backpressure, about 50% duty -> output stream identical to REQ-023; no byte dropped or duplicated; m_data stable while stalled.
REQ-027 cfg_len=0 -> trailer FF FF FF FF emitted with no input consumed; rst_n pulsed after 4 payload bytes -> all outputs 0, next frame CRC correct.
